edge_level_generator: RTL and testbench

- Inverse of the rising/falling edge detector: accepts rise/fall edge commands and rebuilds a registered level waveform `a_o`.
- Enforces a programmable minimum pulse width, so every edge on `a_o` is separated by at least MIN_WIDTH cycles.
- Counts the edges it produces.
- Used as a stimulus source for, and loopback partner of, the edge detector in the same clock domain.

---
 rtl/edge_level_generator_if.sv | 26 ++
 rtl/edge_level_generator.sv | 162 ++++++++++++++++
 tb/tb_edge_level_generator.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/edge_level_generator_if.sv
// Request/status bundle for edge_level_generator.
// master: drives rise/fall requests; slave: returns level, ready, pulses, counts.
interface edge_level_generator_if #(
   parameter int unsigned CNT_W = 8
);
   logic             rise_req_i;
   logic             fall_req_i;
   logic             ready_o;
   logic             a_o;
   logic             drop_o;
   logic             cmd_err_o;
   logic [CNT_W-1:0] rise_cnt_o;
   logic [CNT_W-1:0] fall_cnt_o;

   modport master (
      output rise_req_i, fall_req_i,
      input  ready_o, a_o, drop_o, cmd_err_o,
      input  rise_cnt_o, fall_cnt_o
   );

   modport slave (
      input  rise_req_i, fall_req_i,
      output ready_o, a_o, drop_o, cmd_err_o,
      output rise_cnt_o, fall_cnt_o
   );
endinterface

// File: rtl/edge_level_generator.sv
// Rebuilds a registered level a_o from rise/fall commands, holding every
// level at least MIN_WIDTH cycles and counting the edges produced.
// Ports: clk, reset (async, active high), bus (slave): rise_req_i,
// fall_req_i in; ready_o, a_o, drop_o, cmd_err_o, rise_cnt_o, fall_cnt_o out.
// Macro EDGE_LEVEL_GEN_PENDING_EN adds a one-deep pending command slot;
// without it, a single request while not ready is dropped.
module edge_level_generator #(
   parameter int unsigned MIN_WIDTH   = 4,
   parameter logic        RESET_LEVEL = 1'b0,
   parameter int unsigned CNT_W       = 8
) (
   input logic                   clk,
   input logic                   reset,
   edge_level_generator_if.slave bus
);

   localparam int unsigned HOLD_W = 8;
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MIN_WIDTH - 1);

   if (MIN_WIDTH < 1 || MIN_WIDTH > 255) begin : g_bad_width
      $error("MIN_WIDTH must be in 1..255");
   end

   typedef enum logic [1:0] {
      LOW,
      HIGH,
      HOLD_LOW,
      HOLD_HIGH
   } state_e;

   state_e            state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              a_q, a_d;
   logic              drop_q, drop_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  rise_cnt_q, rise_cnt_d;
   logic [CNT_W-1:0]  fall_cnt_q, fall_cnt_d;

   logic idle;
   logic ready;
   logic single;
   logic both;
   logic exec_vld;
   logic exec_lvl;
   logic pend_vld_q;

`ifdef EDGE_LEVEL_GEN_PENDING_EN
   logic pend_vld_d;
   logic pend_lvl_q, pend_lvl_d;
`else
   assign pend_vld_q = 1'b0;
`endif

   assign idle   = (state_q == LOW) || (state_q == HIGH);
   assign ready  = idle && !pend_vld_q;
   assign single = bus.rise_req_i ^ bus.fall_req_i;
   assign both   = bus.rise_req_i & bus.fall_req_i;

   always_comb begin
      exec_vld   = 1'b0;
      exec_lvl   = a_q;
      drop_d     = 1'b0;
      // Simultaneous rise+fall is flagged and never counts as a drop.
      err_d      = both;
      a_d        = a_q;
      hold_d     = (hold_q == '0) ? '0 : hold_q - HOLD_W'(1);
      rise_cnt_d = rise_cnt_q;
      fall_cnt_d = fall_cnt_q;
      state_d    = state_q;
`ifdef EDGE_LEVEL_GEN_PENDING_EN
      pend_vld_d = pend_vld_q;
      pend_lvl_d = pend_lvl_q;

      // Stored command fires on the first free cycle; it blocks ready
      // that cycle, so any new request then is dropped.
      if (idle && pend_vld_q) begin
         exec_vld   = 1'b1;
         exec_lvl   = pend_lvl_q;
         pend_vld_d = 1'b0;
      end

      if (single) begin
         if (ready) begin
            exec_vld = 1'b1;
            exec_lvl = bus.rise_req_i;
         end else if (!idle && !pend_vld_q) begin
            pend_vld_d = 1'b1;
            pend_lvl_d = bus.rise_req_i;
         end else begin
            drop_d = 1'b1;
         end
      end
`else
      if (single) begin
         if (ready) begin
            exec_vld = 1'b1;
            exec_lvl = bus.rise_req_i;
         end else begin
            drop_d = 1'b1;
         end
      end
`endif

      // Redundant commands fall through here with no effect.
      if (exec_vld && (exec_lvl != a_q)) begin
         a_d    = exec_lvl;
         hold_d = HOLD_LOAD;
         if (exec_lvl) begin
            rise_cnt_d = rise_cnt_q + CNT_W'(1);
         end else begin
            fall_cnt_d = fall_cnt_q + CNT_W'(1);
         end
      end

      unique case ({a_d, hold_d != '0})
         2'b00: state_d = LOW;
         2'b10: state_d = HIGH;
         2'b01: state_d = HOLD_LOW;
         2'b11: state_d = HOLD_HIGH;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= RESET_LEVEL ? HIGH : LOW;
         hold_q     <= '0;
         a_q        <= RESET_LEVEL;
         drop_q     <= 1'b0;
         err_q      <= 1'b0;
         rise_cnt_q <= '0;
         fall_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         a_q        <= a_d;
         drop_q     <= drop_d;
         err_q      <= err_d;
         rise_cnt_q <= rise_cnt_d;
         fall_cnt_q <= fall_cnt_d;
      end
   end

`ifdef EDGE_LEVEL_GEN_PENDING_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_vld_q <= 1'b0;
         pend_lvl_q <= 1'b0;
      end else begin
         pend_vld_q <= pend_vld_d;
         pend_lvl_q <= pend_lvl_d;
      end
   end
`endif

   assign bus.ready_o    = ready;
   assign bus.a_o        = a_q;
   assign bus.drop_o     = drop_q;
   assign bus.cmd_err_o  = err_q;
   assign bus.rise_cnt_o = rise_cnt_q;
   assign bus.fall_cnt_o = fall_cnt_q;

endmodule

// File: tb/tb_edge_level_generator.sv
// Bench for edge_level_generator: two instances (MIN_WIDTH 4 and 1) share
// stimulus and are checked against a timestamp-based reference model.
module tb_edge_level_generator;

   localparam int CNT_W = 8;
`ifdef EDGE_LEVEL_GEN_PENDING_EN
   localparam bit PEND = 1'b1;
`else
   localparam bit PEND = 1'b0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic rise  = 1'b0;
   logic fall  = 1'b0;

   always #5 clk = ~clk;

   edge_level_generator_if #(.CNT_W(CNT_W)) bus4 ();
   edge_level_generator_if #(.CNT_W(CNT_W)) bus1 ();

   assign bus4.rise_req_i = rise;
   assign bus4.fall_req_i = fall;
   assign bus1.rise_req_i = rise;
   assign bus1.fall_req_i = fall;

   edge_level_generator #(
      .MIN_WIDTH(4), .RESET_LEVEL(1'b0), .CNT_W(CNT_W)
   ) dut4 (
      .clk(clk), .reset(reset), .bus(bus4.slave)
   );

   edge_level_generator #(
      .MIN_WIDTH(1), .RESET_LEVEL(1'b0), .CNT_W(CNT_W)
   ) dut1 (
      .clk(clk), .reset(reset), .bus(bus1.slave)
   );

   logic             o_rdy[2], o_a[2], o_drop[2], o_err[2];
   logic [CNT_W-1:0] o_rc[2], o_fc[2];

   assign o_rdy[0]  = bus4.ready_o;
   assign o_a[0]    = bus4.a_o;
   assign o_drop[0] = bus4.drop_o;
   assign o_err[0]  = bus4.cmd_err_o;
   assign o_rc[0]   = bus4.rise_cnt_o;
   assign o_fc[0]   = bus4.fall_cnt_o;
   assign o_rdy[1]  = bus1.ready_o;
   assign o_a[1]    = bus1.a_o;
   assign o_drop[1] = bus1.drop_o;
   assign o_err[1]  = bus1.cmd_err_o;
   assign o_rc[1]   = bus1.rise_cnt_o;
   assign o_fc[1]   = bus1.fall_cnt_o;

   // Reference model: level, cycle of last level change, pending slot.
   int          mw[2] = '{4, 1};
   bit          m_lvl[2], m_pv[2], m_pl[2], m_drop[2], m_err[2];
   int          m_last[2];
   int unsigned m_rc[2], m_fc[2];
   int          cyc;
   int          run[2];
   bit          prev[2], exempt[2];
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_lvl[i]  = 1'b0;
         m_pv[i]   = 1'b0;
         m_pl[i]   = 1'b0;
         m_drop[i] = 1'b0;
         m_err[i]  = 1'b0;
         m_last[i] = -1000;
         m_rc[i]   = 0;
         m_fc[i]   = 0;
         run[i]    = 1;
         prev[i]   = 1'b0;
         exempt[i] = 1'b1;
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("%s_a[%0d]", tag, i), o_a[i], 0);
         chk($sformatf("%s_rdy[%0d]", tag, i), o_rdy[i], 1);
         chk($sformatf("%s_drop[%0d]", tag, i), o_drop[i], 0);
         chk($sformatf("%s_err[%0d]", tag, i), o_err[i], 0);
         chk($sformatf("%s_rc[%0d]", tag, i), o_rc[i], 0);
         chk($sformatf("%s_fc[%0d]", tag, i), o_fc[i], 0);
      end
   endtask

   // Present one cycle of requests, advance one clock, compare.
   task automatic step(input bit r, input bit f);
      bit free, rdy, ex, el;
      rise = r;
      fall = f;
      for (int i = 0; i < 2; i++) begin
         free = (cyc - m_last[i]) >= (mw[i] - 1);
         rdy  = free && !m_pv[i];
         chk($sformatf("ready[%0d]", i), o_rdy[i], rdy);
         m_err[i]  = r & f;
         m_drop[i] = 1'b0;
         ex = 1'b0;
         el = 1'b0;
         if (PEND && free && m_pv[i]) begin
            ex      = 1'b1;
            el      = m_pl[i];
            m_pv[i] = 1'b0;
         end
         if (r != f) begin
            if (rdy) begin
               ex = 1'b1;
               el = r;
            end else if (PEND && !free && !m_pv[i]) begin
               m_pv[i] = 1'b1;
               m_pl[i] = r;
            end else begin
               m_drop[i] = 1'b1;
            end
         end
         if (ex && el != m_lvl[i]) begin
            m_lvl[i]  = el;
            m_last[i] = cyc + 1;
            if (el) m_rc[i]++;
            else    m_fc[i]++;
         end
      end
      cyc++;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("a[%0d]", i), o_a[i], m_lvl[i]);
         chk($sformatf("drop[%0d]", i), o_drop[i], m_drop[i]);
         chk($sformatf("err[%0d]", i), o_err[i], m_err[i]);
         chk($sformatf("rcnt[%0d]", i), o_rc[i], m_rc[i] % 256);
         chk($sformatf("fcnt[%0d]", i), o_fc[i], m_fc[i] % 256);
         if (o_a[i] !== prev[i]) begin
            if (!exempt[i])
               chk($sformatf("run_ok[%0d]", i), run[i] >= mw[i], 1);
            exempt[i] = 1'b0;
            run[i]    = 1;
            prev[i]   = o_a[i];
         end else begin
            run[i]++;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0);
   endtask

   initial begin
      int v;
      model_reset();
      cyc = 0;
      @(posedge clk);
      #1;
      chk_reset_vals("por");
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Directed basic / early-request sequence (cycle 0 onward).
      idle(2);
      step(1'b1, 1'b0);
      chk("basic_rise", o_a[0], 1);
      chk("hold_rdy", o_rdy[0], 0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      chk("early_drop", o_drop[0], PEND ? 0 : 1);
      step(1'b0, 1'b1);
      chk("full_drop", o_drop[0], 1);
      step(1'b0, 1'b0);
      chk("early_a", o_a[0], PEND ? 0 : 1);
      step(1'b0, 1'b1);
      idle(4);
      chk("basic_rc", o_rc[0], 1);
      chk("basic_fc", o_fc[0], 1);

      // Simultaneous request, then a redundant rise.
      step(1'b1, 1'b1);
      chk("both_err", o_err[0], 1);
      chk("both_a", o_a[0], 0);
      step(1'b0, 1'b0);
      chk("err_pulse", o_err[0], 0);
      step(1'b1, 1'b0);
      idle(4);
      step(1'b1, 1'b0);
      chk("redund_drop", o_drop[0], 0);
      chk("redund_err", o_err[0], 0);
      chk("redund_rc", o_rc[0], 2);

      // Randomized traffic.
      for (int k = 0; k < 400; k++) begin
         v = int'($urandom_range(0, 99));
         step((v < 40) || (v >= 92), ((v >= 40) && (v < 80)) || (v >= 92));
      end

      // Drive level high, then reset asynchronously mid-cycle.
      idle(6);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      chk("pre_rst_a", o_a[0], 1);
      #3;
      reset = 1'b1;
      #1;
      chk_reset_vals("arst");
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Counter wrap: 256 rise/fall pairs on alternate cycles.
      for (int k = 0; k < 256; k++) begin
         step(1'b1, 1'b0);
         step(1'b0, 1'b1);
      end
      chk("wrap_rc", o_rc[1], 0);
      chk("wrap_fc", o_fc[1], 0);
      chk("wrap_a", o_a[1], 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
